seq_gen: RTL

- Serial pattern transmitter; the generating end of the 6-bit sequence-detector link.
- On a start request, emits 110010 when btn=1 or 110110 when btn=0 on a single serial line, MSB first, one bit per clock.
- Repeats the pattern REPS times, with GAP idle cycles between repetitions.
- Drives the detector's x input in loopback test rigs and on-board demos.

---
 rtl/seq_gen.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter for the 6-bit sequence-detector link.
//
// On an accepted start, sends PAT_A (btn=1) or PAT_B (btn=0) MSB first on x,
// one bit per clock. The pattern is repeated REPS times, with GAP idle cycles
// between repetitions. A single-cycle done pulse follows the final bit.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   transmission request, sampled only in IDLE
//   btn    in   pattern select, latched with the accepted start
//   x      out  serial data bit (0 whenever valid=0)
//   valid  out  high while x carries a pattern (or parity) bit
//   busy   out  high from accepted start until transmission ends
//   done   out  one-cycle pulse after the last bit of the last repetition
//
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// after every repetition of the pattern.
module seq_gen #(
    parameter int unsigned    LEN   = 6,
    parameter logic [LEN-1:0] PAT_A = 6'b110010,
    parameter logic [LEN-1:0] PAT_B = 6'b110110,
    parameter int unsigned    REPS  = 1,
    parameter int unsigned    GAP   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic btn,
    output logic x,
    output logic valid,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = $clog2(LEN + 2);
    localparam logic [CW-1:0] LAST_DATA = CW'(LEN - 1);
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(LEN);
`else
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);
`endif
    localparam logic [7:0] REPS_M1 = 8'(REPS - 1);
    localparam logic [7:0] GAP_M1  = 8'(GAP - 1);
    localparam bit         HAS_GAP = (GAP != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPS  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LEN-1:0]  sr_q, sr_d;
    logic            sel_q, sel_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      rep_cnt_q, rep_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            x_q, x_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LEN-1:0]  pat_sel;
    logic [LEN-1:0]  sr_shift;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        sel_d     = sel_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        // Latched pattern for reloads; the btn input is not consulted again.
        pat_sel  = sel_q ? PAT_A : PAT_B;
        sr_shift = sr_q << 1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = btn;
                    sr_d      = btn ? PAT_A : PAT_B;
                    x_d       = btn ? PAT_A[LEN-1] : PAT_B[LEN-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                busy_d = 1'b1;
                if (bit_cnt_q != LAST) begin
                    // x_q holds sr_q's MSB, so the next bit is the MSB after shifting.
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    sr_d      = sr_shift;
                    valid_d   = 1'b1;
                    x_d       = sr_shift[LEN-1];
`ifdef SEQ_GEN_PARITY_EN
                    if (bit_cnt_q == LAST_DATA) begin
                        x_d = ^pat_sel;
                    end
`endif
                end else begin
                    rep_cnt_d = rep_cnt_q + 8'd1;
                    if (rep_cnt_q != REPS_M1) begin
                        if (HAS_GAP) begin
                            gap_cnt_d = '0;
                            state_d   = GAPS;
                        end else begin
                            sr_d      = pat_sel;
                            x_d       = pat_sel[LEN-1];
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            GAPS: begin
                busy_d = 1'b1;
                if (gap_cnt_q == GAP_M1) begin
                    sr_d      = pat_sel;
                    x_d       = pat_sel[LEN-1];
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            sel_q     <= 1'b0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            sel_q     <= sel_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
